// File: rtl/arm_decode_stage.sv
// arm_decode_stage
//   Decode / operand-fetch stage of the pipelined ARM core. Sits between
//   fetch and execute: drives register-file read addresses, substitutes
//   R15 and bypasses same-cycle writeback data, decodes the instruction into
//   control fields plus an extended immediate, and registers it all into the
//   ID/EX pipeline register.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   if_valid/if_instr/    instruction presented by fetch, with its PC+8;
//   if_pcplus8/if_ready   if_ready says the stage takes it this cycle
//   flush                 drop presented instruction, invalidate ID/EX
//   ex_ready              execute can take ID/EX contents this cycle
//   a1, a2 / rd1, rd2     register-file read addresses (comb) and data
//   wb_*                  writeback port, used for same-cycle bypass
//   ex_*                  ID/EX register contents (ex_undef: one-cycle pulse
//                         marking a consumed undefined instruction)
module arm_decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pcplus8,
    output logic        if_ready,
    input  logic        flush,
    input  logic        ex_ready,
    output logic [3:0]  a1,
    output logic [3:0]  a2,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    input  logic [1:0]  wb_regwrite,
    input  logic [3:0]  wb_a3,
    input  logic [31:0] wb_wd3,
    input  logic [31:0] wb_pcplus8,
    output logic        ex_valid,
    output logic [3:0]  ex_cond,
    output logic [1:0]  ex_op,
    output logic [5:0]  ex_funct,
    output logic [31:0] ex_srca,
    output logic [31:0] ex_srcb,
    output logic [31:0] ex_imm,
    output logic [3:0]  ex_rd,
    output logic [1:0]  ex_regwrite,
    output logic        ex_memwrite,
    output logic        ex_memtoreg,
    output logic        ex_branch,
    output logic [31:0] ex_pcplus8,
    output logic        ex_undef
);

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] RW_NONE = 2'b00;
    localparam logic [1:0] RW_REG  = 2'b01;
    localparam logic [1:0] RW_LINK = 2'b11;

    typedef struct packed {
        logic        valid;
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [31:0] srca;
        logic [31:0] srcb;
        logic [31:0] imm;
        logic [3:0]  rd;
        logic [1:0]  regwrite;
        logic        memwrite;
        logic        memtoreg;
        logic        branch;
        logic [31:0] pcplus8;
        logic        undef;
    } idex_t;

    typedef enum logic {S_RUN, S_BUBBLE} state_t;

    // ------------------------------------------------------------------
    // Field decode
    // ------------------------------------------------------------------
    logic [1:0]  op;
    logic [3:0]  dec_rd;
    logic [1:0]  dec_regwrite;
    logic        dec_memwrite;
    logic        dec_memtoreg;
    logic        dec_branch;
    logic [31:0] dec_imm;
    logic        use_a;
    logic        use_b;
    logic [63:0] rot_dbl;
    logic [63:0] rot_sh;

    assign op = if_instr[27:26];

    // Rotate-right of the 8-bit immediate: shift a doubled copy so the bits
    // falling off the bottom reappear at the top.
    assign rot_dbl = {2{24'd0, if_instr[7:0]}};
    assign rot_sh  = rot_dbl >> {if_instr[11:8], 1'b0};

    always_comb begin
        a1           = if_instr[19:16];
        a2           = if_instr[3:0];
        dec_rd       = if_instr[15:12];
        dec_regwrite = RW_NONE;
        dec_memwrite = 1'b0;
        dec_memtoreg = 1'b0;
        dec_branch   = 1'b0;
        dec_imm      = 32'd0;
        use_a        = 1'b0;
        use_b        = 1'b0;
        case (op)
            OP_DP: begin
                // TST/TEQ/CMP/CMN only set flags
                dec_regwrite = (if_instr[24:23] == 2'b10) ? RW_NONE : RW_REG;
                dec_imm      = rot_sh[31:0];
                use_a        = 1'b1;
                use_b        = ~if_instr[25];
            end
            OP_MEM: begin
                a2      = if_instr[15:12];
                dec_imm = {20'd0, if_instr[11:0]};
                use_a   = 1'b1;
                use_b   = ~if_instr[20];     // only stores read Rd
                if (if_instr[20]) begin
                    dec_regwrite = RW_REG;
                    dec_memtoreg = 1'b1;
                end else begin
                    dec_memwrite = 1'b1;
                end
            end
            OP_BR: begin
                a1         = 4'd15;
                a2         = 4'd0;
                dec_branch = 1'b1;
                dec_imm    = {{6{if_instr[23]}}, if_instr[23:0], 2'b00};
                if (if_instr[24]) begin
                    dec_regwrite = RW_LINK;
                    dec_rd       = 4'd14;
                end
            end
            default: ;                        // undefined: no controls
        endcase
    end

    // ------------------------------------------------------------------
    // Operand selection. The register file's R15 lags a cycle, so PC+8 of
    // this instruction wins; then same-cycle writeback bypass, then link.
    // ------------------------------------------------------------------
    function automatic logic [31:0] operand_sel(
        input logic [3:0]  addr,
        input logic [31:0] rf_data,
        input logic [31:0] pc8,
        input logic [1:0]  wb_rw,
        input logic [3:0]  wb_addr,
        input logic [31:0] wb_data,
        input logic [31:0] wb_pc8
    );
        if (addr == 4'd15)                          return pc8;
        else if (wb_rw == RW_REG && wb_addr == addr) return wb_data;
        else if (wb_rw == RW_LINK && addr == 4'd14)  return wb_pc8 - 32'd4;
        else                                        return rf_data;
    endfunction

    logic [31:0] opnd_a;
    logic [31:0] opnd_b;

    assign opnd_a = operand_sel(a1, rd1, if_pcplus8, wb_regwrite, wb_a3, wb_wd3, wb_pcplus8);
    assign opnd_b = operand_sel(a2, rd2, if_pcplus8, wb_regwrite, wb_a3, wb_wd3, wb_pcplus8);

    // ------------------------------------------------------------------
    // Load-use hazard against the instruction sitting in ID/EX
    // ------------------------------------------------------------------
    idex_t  idex_q, idex_d;
    state_t state_q, state_d;
    logic   hazard;
    logic   hazard_run;
    logic   accept;
    logic   op_undef;

    assign hazard = idex_q.valid && idex_q.memtoreg && (idex_q.rd != 4'd15) && if_valid &&
                    ((use_a && a1 == idex_q.rd) || (use_b && a2 == idex_q.rd));

    assign op_undef = (op == 2'b11);
    assign accept   = if_valid & if_ready & ~flush;

    // ------------------------------------------------------------------
    // Interlock FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush)                              state_d = S_RUN;
        else if (state_q == S_BUBBLE)           state_d = S_RUN;
        else if (hazard && ex_ready)            state_d = S_BUBBLE;
    end

    always_comb begin
        hazard_run = (state_q == S_RUN) && hazard;
        if_ready   = (ex_ready & ~hazard_run) | flush;
    end

    // ------------------------------------------------------------------
    // ID/EX register. A bubble clears valid and the control bits; datapath
    // fields are left as they were since nothing downstream looks at them.
    // ------------------------------------------------------------------
    always_comb begin
        idex_d       = idex_q;
        idex_d.undef = 1'b0;
        if (accept) begin
            idex_d.valid    = ~op_undef;
            idex_d.undef    = op_undef;
            idex_d.cond     = if_instr[31:28];
            idex_d.op       = op;
            idex_d.funct    = if_instr[25:20];
            idex_d.srca     = opnd_a;
            idex_d.srcb     = opnd_b;
            idex_d.imm      = dec_imm;
            idex_d.rd       = dec_rd;
            idex_d.regwrite = dec_regwrite;
            idex_d.memwrite = dec_memwrite;
            idex_d.memtoreg = dec_memtoreg;
            idex_d.branch   = dec_branch;
            idex_d.pcplus8  = if_pcplus8;
        end else if (flush || ex_ready) begin
            idex_d.valid    = 1'b0;
            idex_d.regwrite = RW_NONE;
            idex_d.memwrite = 1'b0;
            idex_d.memtoreg = 1'b0;
            idex_d.branch   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) idex_q <= '0;
        else       idex_q <= idex_d;
    end

    assign ex_valid    = idex_q.valid;
    assign ex_cond     = idex_q.cond;
    assign ex_op       = idex_q.op;
    assign ex_funct    = idex_q.funct;
    assign ex_srca     = idex_q.srca;
    assign ex_srcb     = idex_q.srcb;
    assign ex_imm      = idex_q.imm;
    assign ex_rd       = idex_q.rd;
    assign ex_regwrite = idex_q.regwrite;
    assign ex_memwrite = idex_q.memwrite;
    assign ex_memtoreg = idex_q.memtoreg;
    assign ex_branch   = idex_q.branch;
    assign ex_pcplus8  = idex_q.pcplus8;
    assign ex_undef    = idex_q.undef;

endmodule

// File: tb/tb_arm_decode_stage.sv
// Directed bench for arm_decode_stage: hand-encoded ARM instructions with
// hand-computed ID/EX contents, covering decode, bypass, interlock, stall,
// flush, undefined op and asynchronous reset.
module tb_arm_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pcplus8;
    logic        if_ready;
    logic        flush;
    logic        ex_ready;
    logic [3:0]  a1, a2;
    logic [31:0] rd1, rd2;
    logic [1:0]  wb_regwrite;
    logic [3:0]  wb_a3;
    logic [31:0] wb_wd3;
    logic [31:0] wb_pcplus8;
    logic        ex_valid;
    logic [3:0]  ex_cond;
    logic [1:0]  ex_op;
    logic [5:0]  ex_funct;
    logic [31:0] ex_srca, ex_srcb, ex_imm;
    logic [3:0]  ex_rd;
    logic [1:0]  ex_regwrite;
    logic        ex_memwrite, ex_memtoreg, ex_branch;
    logic [31:0] ex_pcplus8;
    logic        ex_undef;

    logic [31:0] rf [16];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign rd1 = rf[a1];
    assign rd2 = rf[a2];

    arm_decode_stage dut (
        .clk(clk), .reset(reset),
        .if_valid(if_valid), .if_instr(if_instr), .if_pcplus8(if_pcplus8), .if_ready(if_ready),
        .flush(flush), .ex_ready(ex_ready),
        .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
        .wb_regwrite(wb_regwrite), .wb_a3(wb_a3), .wb_wd3(wb_wd3), .wb_pcplus8(wb_pcplus8),
        .ex_valid(ex_valid), .ex_cond(ex_cond), .ex_op(ex_op), .ex_funct(ex_funct),
        .ex_srca(ex_srca), .ex_srcb(ex_srcb), .ex_imm(ex_imm), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_branch(ex_branch), .ex_pcplus8(ex_pcplus8), .ex_undef(ex_undef)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc8);
        if_valid   = 1'b1;
        if_instr   = instr;
        if_pcplus8 = pc8;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 32'h1000 + i;
        rf[2]  = 32'd5;
        rf[3]  = 32'd7;
        rf[14] = 32'h5555;
        rf[15] = 32'hDEAD;

        reset = 1'b0; if_valid = 1'b0; if_instr = 32'd0; if_pcplus8 = 32'd0;
        flush = 1'b0; ex_ready = 1'b1;
        wb_regwrite = 2'b00; wb_a3 = 4'd0; wb_wd3 = 32'd0; wb_pcplus8 = 32'd0;
        #1 reset = 1'b1;
        #2;
        chk("rst_valid", ex_valid, 0);
        chk("rst_srca", ex_srca, 0);
        chk("rst_imm", ex_imm, 0);
        chk("rst_regwrite", ex_regwrite, 0);
        chk("rst_undef", ex_undef, 0);
        chk("rst_if_ready", if_ready, 1);
        #8 reset = 1'b0;

        // ADD R1,R2,R3
        issue(32'hE0821003, 32'h100);
        chk("add_valid", ex_valid, 1);
        chk("add_srca", ex_srca, 5);
        chk("add_srcb", ex_srcb, 7);
        chk("add_rd", ex_rd, 1);
        chk("add_regwrite", ex_regwrite, 2'b01);
        chk("add_pc8", ex_pcplus8, 32'h100);
        chk("add_cond", ex_cond, 4'hE);
        chk("add_funct", ex_funct, 6'h08);

        // CMP R1,R2 : flags only
        issue(32'hE1510002, 32'h104);
        chk("cmp_regwrite", ex_regwrite, 2'b00);
        chk("cmp_valid", ex_valid, 1);

        // MOV R0,#0xFF ror 8
        issue(32'hE3A004FF, 32'h108);
        chk("mov_imm", ex_imm, 32'hFF000000);
        chk("mov_regwrite", ex_regwrite, 2'b01);

        // B -8 : srcA is PC+8 of the branch
        issue(32'hEAFFFFFE, 32'h300);
        chk("b_imm", ex_imm, 32'hFFFFFFF8);
        chk("b_branch", ex_branch, 1);
        chk("b_regwrite", ex_regwrite, 2'b00);
        chk("b_op", ex_op, 2'b10);
        chk("b_srca", ex_srca, 32'h300);

        // BL +0x40
        issue(32'hEB000010, 32'h304);
        chk("bl_regwrite", ex_regwrite, 2'b11);
        chk("bl_rd", ex_rd, 14);
        chk("bl_imm", ex_imm, 32'h40);

        // ADD R7,R4,R3 with writeback of R4 in flight
        wb_regwrite = 2'b01; wb_a3 = 4'd4; wb_wd3 = 32'h1234;
        issue(32'hE0847003, 32'h110);
        chk("byp_srca", ex_srca, 32'h1234);
        chk("byp_srcb", ex_srcb, 7);
        wb_regwrite = 2'b00;

        // ADD R8,R15,R3 : R15 reads PC+8
        issue(32'hE08F8003, 32'h108);
        chk("r15_srca", ex_srca, 32'h108);

        // ADD R9,R14,R3 while a BL writes the link register
        wb_regwrite = 2'b11; wb_pcplus8 = 32'h200;
        issue(32'hE08E9003, 32'h118);
        chk("link_srca", ex_srca, 32'h1FC);
        wb_regwrite = 2'b00;

        // STR R2,[R3,#4]
        issue(32'hE5832004, 32'h11C);
        chk("str_memwrite", ex_memwrite, 1);
        chk("str_regwrite", ex_regwrite, 0);
        chk("str_srca", ex_srca, 7);
        chk("str_srcb", ex_srcb, 5);
        chk("str_imm", ex_imm, 4);

        // LDR R5,[R0] then ADD R6,R5,R1 : one stall cycle, one bubble
        issue(32'hE5905000, 32'h120);
        chk("ldr_memtoreg", ex_memtoreg, 1);
        chk("ldr_regwrite", ex_regwrite, 2'b01);
        chk("ldr_rd", ex_rd, 5);
        chk("ldr_srca", ex_srca, 32'h1000);
        if_instr = 32'hE0856001; if_pcplus8 = 32'h124;
        #1;
        chk("lu_if_ready_stall", if_ready, 0);
        tick();
        chk("lu_bubble_valid", ex_valid, 0);
        chk("lu_if_ready_bubble", if_ready, 1);
        tick();
        chk("lu_add_valid", ex_valid, 1);
        chk("lu_add_rd", ex_rd, 6);
        chk("lu_add_srca", ex_srca, 32'h1005);

        // LDR R5 then ADD R6,R1,#5 : Rm field equals 5 but is unused
        issue(32'hE5905000, 32'h128);
        if_instr = 32'hE2816005; if_pcplus8 = 32'h12C;
        #1;
        chk("nolu_if_ready", if_ready, 1);
        tick();
        chk("nolu_valid", ex_valid, 1);
        chk("nolu_rd", ex_rd, 6);
        chk("nolu_imm", ex_imm, 5);

        // LDR R5 then STR R5,[R1] : hazard through port B
        issue(32'hE5905000, 32'h130);
        if_instr = 32'hE5815000; if_pcplus8 = 32'h134;
        #1;
        chk("lub_if_ready", if_ready, 0);
        tick();
        chk("lub_bubble_valid", ex_valid, 0);
        tick();
        chk("lub_str_memwrite", ex_memwrite, 1);
        chk("lub_str_srcb", ex_srcb, 32'h1005);

        // Downstream stall for 3 cycles, then flush during the stall
        issue(32'hE0821003, 32'h140);
        ex_ready = 1'b0;
        if_instr = 32'hE3A004FF; if_pcplus8 = 32'h144;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_if_ready", if_ready, 0);
            chk("stall_valid", ex_valid, 1);
            chk("stall_srca", ex_srca, 5);
            chk("stall_rd", ex_rd, 1);
            chk("stall_pc8", ex_pcplus8, 32'h140);
        end
        flush = 1'b1;
        #1;
        chk("flush_if_ready", if_ready, 1);
        tick();
        chk("flush_valid", ex_valid, 0);
        flush = 1'b0; ex_ready = 1'b1;

        // Undefined op: single ex_undef pulse, no valid
        issue(32'hEC000000, 32'h150);
        chk("undef_pulse", ex_undef, 1);
        chk("undef_valid", ex_valid, 0);
        if_valid = 1'b0;
        tick();
        chk("undef_cleared", ex_undef, 0);

        // Reset asserted while in the bubble cycle clears outputs at once
        issue(32'hE5905000, 32'h160);
        if_instr = 32'hE0856001; if_pcplus8 = 32'h164;
        tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_srca", ex_srca, 0);
        chk("arst_rd", ex_rd, 0);
        chk("arst_pc8", ex_pcplus8, 0);
        chk("arst_valid", ex_valid, 0);
        #3 reset = 1'b0;
        if_valid = 1'b1; if_instr = 32'hE0821003; if_pcplus8 = 32'h170;
        tick();
        chk("post_rst_valid", ex_valid, 1);
        chk("post_rst_rd", ex_rd, 1);
        chk("post_rst_srcb", ex_srcb, 7);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
